// File: rtl/hd44780_lcd_responder.sv
// rtl/hd44780_lcd_responder.sv - HD44780-class LCD bus responder with DDRAM, AC, mode flags and busy model
module hd44780_lcd_responder #(
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] addr_cnt,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       eight_bit,
  output logic       cmd_strobe,
  output logic       wr_strobe,
  output logic       protocol_err
);

  localparam int CNT_MAX = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEARING, S_BUSY} state_t;

  state_t           r_state, w_next;
  logic [SYNC_STAGES-1:0] r_en_sync, r_rs_sync, r_rw_sync;
  logic [7:0]       r_data_sync [SYNC_STAGES];
  logic             r_en_prev;
  logic [7:0]       r_ddram [128];
  logic [7:0]       r_rd_char;
  logic [6:0]       r_ac, r_sweep;
  logic [CW-1:0]    r_cnt;
  logic             r_inc, r_disp, r_cursor, r_blink, r_two, r_eight, r_err;
  logic             r_x_rs;
  logic [7:0]       r_x_data;

  logic             w_fall, w_rs, w_rw, w_accept, w_is_clear, w_is_home;
  logic [7:0]       w_data;

  // Next AC value: line-boundary wraps at exact wrap points, plain 7-bit arithmetic elsewhere
  function automatic logic [6:0] f_step(input logic [6:0] ac, input logic inc, input logic two);
    logic [6:0] res;
    if (inc) begin
      if (two && ac == 7'h27)       res = 7'h40;
      else if (two && ac == 7'h67)  res = 7'h00;
      else if (!two && ac == 7'h4F) res = 7'h00;
      else                          res = ac + 7'd1;
    end else begin
      if (two && ac == 7'h40)       res = 7'h27;
      else if (two && ac == 7'h00)  res = 7'h67;
      else if (!two && ac == 7'h00) res = 7'h4F;
      else                          res = ac - 7'd1;
    end
    return res;
  endfunction

  assign w_fall     = r_en_prev & ~r_en_sync[SYNC_STAGES-1];
  assign w_rs       = r_rs_sync[SYNC_STAGES-1];
  assign w_rw       = r_rw_sync[SYNC_STAGES-1];
  assign w_data     = r_data_sync[SYNC_STAGES-1];
  assign w_accept   = (r_state == S_IDLE) & w_fall & ~w_rw & (w_rs | (w_data != 8'h00));
  assign w_is_clear = ~r_x_rs & (r_x_data == 8'h01);
  assign w_is_home  = ~r_x_rs & (r_x_data[7:1] == 7'b0000001);

  // Bus synchronizer: enable and its companion signals shift through matching stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_sync <= '0;
      r_rs_sync <= '0;
      r_rw_sync <= '0;
      r_en_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= 8'h00;
    end else begin
      r_en_sync[0]   <= lcd_en;
      r_rs_sync[0]   <= lcd_rs;
      r_rw_sync[0]   <= lcd_rw;
      r_data_sync[0] <= lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_en_sync[i]   <= r_en_sync[i-1];
        r_rs_sync[i]   <= r_rs_sync[i-1];
        r_rw_sync[i]   <= r_rw_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_en_prev <= r_en_sync[SYNC_STAGES-1];
    end
  end

  // State register; reset lands in the power-on clear sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEARING;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_EXEC;
      S_EXEC:     w_next = w_is_clear ? S_CLEARING : S_BUSY;
      S_CLEARING: if (r_sweep == 7'h7F) w_next = S_BUSY;
      S_BUSY:     if (r_cnt <= CNT_ONE) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Transfer capture, instruction execution, AC/flags, sweep and busy counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac     <= 7'h00;
      r_inc    <= 1'b1;
      r_disp   <= 1'b0;
      r_cursor <= 1'b0;
      r_blink  <= 1'b0;
      r_two    <= 1'b0;
      r_eight  <= 1'b0;
      r_err    <= 1'b0;
      r_sweep  <= 7'h00;
      r_cnt    <= CLEAR_LOAD;
      r_x_rs   <= 1'b0;
      r_x_data <= 8'h00;
    end else begin
      if (w_fall && r_state != S_IDLE) r_err <= 1'b1;
      if (w_accept) begin
        r_x_rs   <= w_rs;
        r_x_data <= w_data;
      end
      case (r_state)
        S_EXEC: begin
          r_cnt   <= (w_is_clear || w_is_home) ? CLEAR_LOAD : BUSY_LOAD;
          r_sweep <= 7'h00;
          if (r_x_rs) begin
            r_ac <= f_step(r_ac, r_inc, r_two);
          end else begin
            casez (r_x_data)
              8'b1???????: r_ac <= r_x_data[6:0];
              8'b001?????: begin
                r_eight <= r_x_data[4];
                r_two   <= r_x_data[3];
              end
              8'b00001???: begin
                r_disp   <= r_x_data[2];
                r_cursor <= r_x_data[1];
                r_blink  <= r_x_data[0];
              end
              8'b000001??: r_inc <= r_x_data[1];
              8'b0000001?: r_ac <= 7'h00;
              8'b00000001: begin
                r_ac  <= 7'h00;
                r_inc <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_CLEARING: begin
          r_sweep <= r_sweep + 7'd1;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
        end
        S_BUSY: if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // DDRAM write port: sweep fills with spaces, data writes land at the current AC
  always_ff @(posedge clk) begin
    if (r_state == S_CLEARING)         r_ddram[r_sweep] <= 8'h20;
    else if (r_state == S_EXEC && r_x_rs) r_ddram[r_ac] <= r_x_data;
  end

  // Registered inspection read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_char <= 8'h00;
    else     r_rd_char <= r_ddram[rd_addr];
  end

  assign rd_char      = r_rd_char;
  assign addr_cnt     = r_ac;
  assign busy         = (r_state != S_IDLE);
  assign disp_on      = r_disp;
  assign cursor_on    = r_cursor;
  assign blink_on     = r_blink;
  assign two_line     = r_two;
  assign eight_bit    = r_eight;
  assign cmd_strobe   = (r_state == S_EXEC) & ~r_x_rs;
  assign wr_strobe    = (r_state == S_EXEC) & r_x_rs;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// tb/tb_hd44780_lcd_responder.sv - self-checking bench for hd44780_lcd_responder
module tb_hd44780_lcd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic       lcd_en, lcd_rs, lcd_rw;
  logic [6:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] addr_cnt;
  logic       busy, disp_on, cursor_on, blink_on, two_line, eight_bit;
  logic       cmd_strobe, wr_strobe, protocol_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd   = 0;
  int n_wr    = 0;

  // reference model state
  logic [7:0] m_ram [128];
  logic [6:0] m_ac;
  logic       m_inc, m_disp, m_cur, m_blink, m_two, m_eight, m_err;
  int         m_cmd = 0;
  int         m_wr  = 0;

  hd44780_lcd_responder #(
    .BUSY_CYCLES(4), .CLEAR_BUSY_CYCLES(200), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .rd_addr(rd_addr), .rd_char(rd_char), .addr_cnt(addr_cnt),
    .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .eight_bit(eight_bit), .cmd_strobe(cmd_strobe),
    .wr_strobe(wr_strobe), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) n_cmd++;
    if (wr_strobe === 1'b1)  n_wr++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a);
    logic [6:0] r;
    if (m_inc) begin
      r = a + 7'd1;
      if (m_two && a == 7'h27) r = 7'h40;
      if (m_two && a == 7'h67) r = 7'h00;
      if (!m_two && a == 7'h4F) r = 7'h00;
    end else begin
      r = a - 7'd1;
      if (m_two && a == 7'h40) r = 7'h27;
      if (m_two && a == 7'h00) r = 7'h67;
      if (!m_two && a == 7'h00) r = 7'h4F;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ac = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
    m_two = 1'b0; m_eight = 1'b0; m_err = 1'b0;
    for (int a = 0; a < 128; a++) m_ram[a] = 8'h20;
  endtask

  task automatic model_apply(input logic rs, input logic [7:0] d);
    int hb;
    if (rs) begin
      m_ram[m_ac] = d;
      m_wr++;
      m_ac = m_step(m_ac);
    end else if (d != 8'h00) begin
      m_cmd++;
      hb = 0;
      for (int b = 0; b < 8; b++) if (d[b]) hb = b;
      case (hb)
        0: begin
          for (int a = 0; a < 128; a++) m_ram[a] = 8'h20;
          m_ac = 7'h00; m_inc = 1'b1;
        end
        1: m_ac = 7'h00;
        2: m_inc = d[1];
        3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        5: begin m_eight = d[4]; m_two = d[3]; end
        7: m_ac = d[6:0];
        default: ;
      endcase
    end
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d, input int width);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    tick(width);
    lcd_en = 1'b0;
    tick(4);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle"}, busy, 0);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    pulse(rs, 1'b0, d, 2);
    wait_idle($sformatf("wr %0b/%02h", rs, d));
    model_apply(rs, d);
  endtask

  task automatic check_ram(input int a, input string tag);
    rd_addr = 7'(a);
    @(negedge clk);
    check($sformatf("%s ram[%02h]", tag, a), rd_char, m_ram[a]);
  endtask

  task automatic check_state(input string tag);
    check({tag, " ac"},     addr_cnt,     m_ac);
    check({tag, " disp"},   disp_on,      m_disp);
    check({tag, " cursor"}, cursor_on,    m_cur);
    check({tag, " blink"},  blink_on,     m_blink);
    check({tag, " two"},    two_line,     m_two);
    check({tag, " eight"},  eight_bit,    m_eight);
    check({tag, " err"},    protocol_err, m_err);
    check({tag, " ncmd"},   n_cmd,        m_cmd);
    check({tag, " nwr"},    n_wr,         m_wr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},   busy,         1);
    check({tag, " ac"},     addr_cnt,     0);
    check({tag, " disp"},   disp_on,      0);
    check({tag, " cursor"}, cursor_on,    0);
    check({tag, " blink"},  blink_on,     0);
    check({tag, " two"},    two_line,     0);
    check({tag, " eight"},  eight_bit,    0);
    check({tag, " cstb"},   cmd_strobe,   0);
    check({tag, " wstb"},   wr_strobe,    0);
    check({tag, " err"},    protocol_err, 0);
    check({tag, " rdchar"}, rd_char,      0);
  endtask

  task automatic release_and_sweep(input string tag);
    int k;
    rst = 1'b0;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, " busy len"}, (k >= 127 && k <= 200), 1);
    model_reset();
    check({tag, " ac"}, addr_cnt, 0);
    for (int a = 0; a < 128; a++) check_ram(a, tag);
  endtask

  initial begin
    int        k, op;
    logic      rs;
    logic [7:0] b;
    logic      seen;

    rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 7'h00;
    tick(3);
    check_reset_outputs("reset");
    release_and_sweep("por");

    // writer init sequence then "a="
    bus_write(1'b0, 8'h38);
    bus_write(1'b0, 8'h0E);
    bus_write(1'b0, 8'h06);
    bus_write(1'b0, 8'h01);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h61);
    bus_write(1'b1, 8'h3D);
    check_state("init");
    check("init ac lit", addr_cnt, 7'h02);
    check("init two lit", two_line, 1);
    check("init ncmd lit", n_cmd, 5);
    check_ram(0, "init");
    check_ram(1, "init");

    // line-boundary wrap in two-line mode
    bus_write(1'b0, 8'hA6);
    bus_write(1'b1, 8'h41);
    bus_write(1'b1, 8'h42);
    check("wrap inc ac", addr_cnt, 7'h40);
    bus_write(1'b0, 8'h04);
    bus_write(1'b1, 8'h43);
    check("wrap dec ac", addr_cnt, 7'h27);
    check_state("wrap");
    check_ram(7'h26, "wrap");
    check_ram(7'h27, "wrap");
    check_ram(7'h40, "wrap");

    // second transfer while busy is dropped and flagged
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h5A; lcd_en = 1'b1;
    tick(2);
    lcd_en = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (wr_strobe === 1'b1) seen = 1'b1;
    end
    check("perr first strobe", seen, 1);
    lcd_data = 8'h55; lcd_en = 1'b1;
    tick(1);
    lcd_en = 1'b0;
    tick(4);
    wait_idle("perr");
    model_apply(1'b1, 8'h5A);
    m_err = 1'b1;
    tick(6);
    check_state("perr");
    check_ram(7'h27, "perr");
    check_ram(7'h26, "perr");
    check("perr lit", protocol_err, 1);

    // reads and no-op: no strobe, no busy
    pulse(1'b1, 1'b1, 8'hFF, 2);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen = 1'b1;
    end
    check("rw data busy", seen, 0);
    pulse(1'b0, 1'b1, 8'hFF, 2);
    pulse(1'b0, 1'b0, 8'h00, 2);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen = 1'b1;
    end
    check("rw/noop busy", seen, 0);
    check_state("rw");

    // randomized instruction/data mix against the model
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      rs = 1'b0;
      case (op)
        0, 1, 2, 3: begin rs = 1'b1; b = 8'($urandom_range(32, 126)); end
        4: b = 8'h04 | 8'($urandom_range(0, 3));
        5: b = 8'h80 | 8'($urandom_range(0, 127));
        6: b = 8'h20 | 8'($urandom_range(0, 31));
        7: b = 8'h08 | 8'($urandom_range(0, 7));
        8: b = (($urandom_range(0, 1) == 1) ? 8'h40 : 8'h10) | 8'($urandom_range(0, 15));
        default: b = 8'h02 | 8'($urandom_range(0, 1));
      endcase
      bus_write(rs, b);
      check($sformatf("rand%0d ac", i), addr_cnt, m_ac);
    end
    check_state("rand");
    for (int a = 0; a < 128; a++) check_ram(a, "rand");

    // reset in the middle of a clear sweep
    pulse(1'b0, 1'b0, 8'h01, 2);
    model_apply(1'b0, 8'h01);
    tick(20);
    check("midclr busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(3);
    release_and_sweep("resweep");
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
